// File: rtl/ibpl_in_pkg.sv
// rtl/ibpl_in_pkg.sv - shared constants, types and helpers for the interbackplane input cardlet
//
// Purpose: channel count, pad-bus width, channel vector type and the counter
//          width helper used by the debounce and LED-stretch counters.
// Ports:   none (package).
package ibpl_in_pkg;

  localparam int NCH   = 6;
  localparam int PAD_W = 8;

  typedef logic [NCH-1:0] ch_vec_t;

  // Pad-bus bits that map onto physical DIOB channels.
  localparam logic [PAD_W-1:0] CH_MASK = {{(PAD_W-NCH){1'b0}}, {NCH{1'b1}}};

  // Width of a counter that must hold 0..n; never less than one bit so that
  // a bypassed debouncer still elaborates cleanly.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ibpl_in_debounce_ch.sv
// rtl/ibpl_in_debounce_ch.sv - one input channel: synchroniser, debouncer, edge detect
//
// Purpose: brings one asynchronous pin into the clk domain through two flops,
//          accepts a new level only after it has differed from the accepted
//          level for DEBOUNCE_CYCLES consecutive cycles, and flags each change
//          of the accepted level with a one-cycle pulse.
// Ports:   clk     in  system clock
//          nReset  in  asynchronous active-low reset
//          pin     in  raw pin level, asynchronous to clk
//          stable  out accepted (debounced) level
//          edge_p  out one-cycle pulse on any change of stable
module ibpl_in_debounce_ch
  import ibpl_in_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic nReset,
  input  logic pin,
  output logic stable,
  output logic edge_p
);

  logic [1:0] sync_q;
  logic       sync;
  logic       stable_d;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) sync_q <= 2'b00;
    else         sync_q <= {sync_q[0], pin};
  end

  assign sync = sync_q[1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) stable <= 1'b0;
        else         stable <= sync;
      end
    end else begin : g_debounce
      localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
      localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] cnt;

      // Counter only runs while sync disagrees with the accepted level, so any
      // bounce back to the accepted level restarts the qualification window.
      always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
          stable <= 1'b0;
          cnt    <= '0;
        end else if (sync == stable) begin
          cnt    <= '0;
        end else if (cnt == CNT_LAST) begin
          stable <= sync;
          cnt    <= '0;
        end else begin
          cnt    <= cnt + 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) stable_d <= 1'b0;
    else         stable_d <= stable;
  end

  assign edge_p = stable ^ stable_d;

endmodule

// File: rtl/ibpl_in_debounce_cardlet.sv
// rtl/ibpl_in_debounce_cardlet.sv - 6-channel debounced DIOB input cardlet
//
// Purpose: drives all DIOB pins as inputs, debounces each channel, presents
//          the enabled debounced levels to the core, stretches per-channel
//          activity pulses onto LED1, mirrors input_enable on LED2 and flags
//          channels configured as outputs without being inputs.
//          Optional sticky edge flags are built when IBPL_IN_EDGE_LATCH_EN is
//          defined; the default build has neither the ports nor the flops.
// Ports:   clk, nReset            clock, asynchronous active-low reset
//          diob_in[6]             raw pin levels
//          diob_dir[6], diob_out[6] pin direction/drive, always 0 (input)
//          internal_out[8]        core output bus, not used here
//          internal_in[8]         debounced, enable-masked levels to core
//          input_enable[8]        per-channel input enable
//          output_enable[8]       per-channel output enable
//          output_act[8]          core activity flags, not used here
//          diob_led1[8]           stretched activity LEDs
//          diob_led2[8]           input-enable LEDs
//          edge_clr[6], edge_flag[6] sticky edge flags (IBPL_IN_EDGE_LATCH_EN)
//          plugin_error           output enabled on a non-input channel
module ibpl_in_debounce_cardlet
  import ibpl_in_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LED_HOLD_CYCLES = 1 << 20
) (
  input  logic             clk,
  input  logic             nReset,
  input  ch_vec_t          diob_in,
  output ch_vec_t          diob_dir,
  output ch_vec_t          diob_out,
  input  logic [PAD_W-1:0] internal_out,
  output logic [PAD_W-1:0] internal_in,
  input  logic [PAD_W-1:0] input_enable,
  input  logic [PAD_W-1:0] output_enable,
  input  logic [PAD_W-1:0] output_act,
  output logic [PAD_W-1:0] diob_led1,
  output logic [PAD_W-1:0] diob_led2,
`ifdef IBPL_IN_EDGE_LATCH_EN
  input  ch_vec_t          edge_clr,
  output ch_vec_t          edge_flag,
`endif
  output logic             plugin_error
);

  localparam int            LW       = cnt_width(LED_HOLD_CYCLES);
  localparam logic [LW-1:0] LED_LOAD = LW'(LED_HOLD_CYCLES);

  ch_vec_t stable;
  ch_vec_t edge_vec;
  ch_vec_t led_on;

  logic unused_inputs;
  assign unused_inputs = ^{internal_out, output_act};

  assign diob_dir  = '0;
  assign diob_out  = '0;
  assign diob_led2 = input_enable & CH_MASK;

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [LW-1:0] led_cnt;

      ibpl_in_debounce_ch #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_ch (
        .clk    (clk),
        .nReset (nReset),
        .pin    (diob_in[i]),
        .stable (stable[i]),
        .edge_p (edge_vec[i])
      );

      // Retrigger reloads the full hold time rather than adding to it.
      always_ff @(posedge clk or negedge nReset) begin
        if (!nReset)              led_cnt <= '0;
        else if (edge_vec[i])     led_cnt <= LED_LOAD;
        else if (led_cnt != '0)   led_cnt <= led_cnt - 1'b1;
      end

      assign led_on[i] = (led_cnt != '0);
    end
  endgenerate

  assign diob_led1 = {{(PAD_W-NCH){1'b0}}, led_on};

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      internal_in  <= '0;
      plugin_error <= 1'b0;
    end else begin
      internal_in  <= {{(PAD_W-NCH){1'b0}}, stable & input_enable[NCH-1:0]};
      plugin_error <= |(output_enable & ~input_enable & CH_MASK);
    end
  end

`ifdef IBPL_IN_EDGE_LATCH_EN
  // Set term is ORed after the clear so a coincident edge keeps the flag.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) edge_flag <= '0;
    else         edge_flag <= (edge_flag & ~edge_clr) | (edge_vec & input_enable[NCH-1:0]);
  end
`endif

endmodule

// File: tb/tb_ibpl_in_debounce_cardlet.sv
// tb/tb_ibpl_in_debounce_cardlet.sv - self-checking bench for ibpl_in_debounce_cardlet
module tb_ibpl_in_debounce_cardlet;

  localparam int DEB      = 16;
  localparam int LED_HOLD = 100;

  logic       clk = 1'b0;
  logic       nReset;
  logic [5:0] diob_in;
  logic [5:0] diob_dir, diob_out;
  logic [7:0] internal_out, internal_in, input_enable, output_enable, output_act;
  logic [7:0] diob_led1, diob_led2;
  logic       plugin_error;
`ifdef IBPL_IN_EDGE_LATCH_EN
  logic [5:0] edge_clr, edge_flag;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ibpl_in_debounce_cardlet #(
    .DEBOUNCE_CYCLES(DEB),
    .LED_HOLD_CYCLES(LED_HOLD)
  ) dut (
    .clk           (clk),
    .nReset        (nReset),
    .diob_in       (diob_in),
    .diob_dir      (diob_dir),
    .diob_out      (diob_out),
    .internal_out  (internal_out),
    .internal_in   (internal_in),
    .input_enable  (input_enable),
    .output_enable (output_enable),
    .output_act    (output_act),
    .diob_led1     (diob_led1),
    .diob_led2     (diob_led2),
`ifdef IBPL_IN_EDGE_LATCH_EN
    .edge_clr      (edge_clr),
    .edge_flag     (edge_flag),
`endif
    .plugin_error  (plugin_error)
  );

  // Reference model: pin history per clock edge since reset; a channel's
  // accepted level flips at edge t when the synchronised samples seen over
  // the last DEB cycles (pins at edges t-2 .. t-1-DEB) all disagree with it.
  logic [5:0] ph [0:8191];
  int         cyc;
  int         last_chg [6];
  logic [5:0] acc, m_led;
  logic [7:0] m_int;
  logic       m_err;
`ifdef IBPL_IN_EDGE_LATCH_EN
  logic [5:0] m_flag, flip_prev;
`endif

  task automatic model_reset();
    cyc   = 0;
    acc   = '0;
    m_led = '0;
    m_int = '0;
    m_err = 1'b0;
    for (int i = 0; i < 6; i++) last_chg[i] = -100000;
`ifdef IBPL_IN_EDGE_LATCH_EN
    m_flag    = '0;
    flip_prev = '0;
`endif
  endtask

  function automatic logic [5:0] p_at(input int idx);
    if (idx < 0) return 6'h00;
    return ph[idx];
  endfunction

  task automatic model_edge();
    logic [5:0] flip;
    if (!nReset) begin
      model_reset();
      return;
    end
    ph[cyc] = diob_in;
    m_int = {2'b00, acc & input_enable[5:0]};
    m_err = |((output_enable & ~input_enable) & 8'h3F);
    for (int i = 0; i < 6; i++) m_led[i] = ((cyc - last_chg[i]) <= LED_HOLD);
`ifdef IBPL_IN_EDGE_LATCH_EN
    m_flag = (m_flag & ~edge_clr) | (flip_prev & input_enable[5:0]);
`endif
    flip = 6'h3F;
    for (int j = 2; j <= DEB + 1; j++) flip &= (p_at(cyc - j) ^ acc);
    for (int i = 0; i < 6; i++) if (flip[i]) last_chg[i] = cyc;
    acc = acc ^ flip;
`ifdef IBPL_IN_EDGE_LATCH_EN
    flip_prev = flip;
`endif
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("internal_in", internal_in, m_int);
    chk("led1", diob_led1, {2'b00, m_led});
    chk("plugin_error", plugin_error, m_err);
    chk("diob_dir", diob_dir, 6'h00);
    chk("diob_out", diob_out, 6'h00);
    chk("led2", diob_led2, {2'b00, input_enable[5:0]});
`ifdef IBPL_IN_EDGE_LATCH_EN
    chk("edge_flag", edge_flag, m_flag);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    model_edge();
    check_all();
  endtask

  initial begin
    int n;
    int on_cnt;
    logic seen_low, seen_led;

    nReset        = 1'b0;
    diob_in       = 6'h00;
    input_enable  = 8'h3F;
    output_enable = 8'h00;
    internal_out  = 8'($urandom);
    output_act    = 8'($urandom);
`ifdef IBPL_IN_EDGE_LATCH_EN
    edge_clr      = 6'h00;
`endif
    model_reset();
    tick();
    chk("rst_internal_in", internal_in, 8'h00);
    chk("rst_led1", diob_led1, 8'h00);
    chk("rst_err", plugin_error, 1'b0);
    tick();
    nReset = 1'b1;

    // Rise on all channels: 2 sync + DEB + 1 output register.
    diob_in = 6'h3F;
    n = 0;
    do begin tick(); n++; end while (internal_in !== 8'h3F && n < 40);
    chk("latency_rise", n, 19);
    repeat (110) tick();

    // Short glitch on ch2 must not propagate.
    diob_in = 6'h3B;
    repeat (10) tick();
    diob_in = 6'h3F;
    repeat (30) begin
      tick();
      chk("glitch_in", internal_in, 8'h3F);
      chk("glitch_led", diob_led1, 8'h00);
    end

    // A DEB-long pulse is accepted and lights LED1[2].
    seen_low = 1'b0;
    seen_led = 1'b0;
    diob_in  = 6'h3B;
    for (int k = 0; k < 56; k++) begin
      if (k == 16) diob_in = 6'h3F;
      tick();
      if (internal_in[2] === 1'b0) seen_low = 1'b1;
      if (diob_led1[2] === 1'b1)   seen_led = 1'b1;
    end
    chk("pulse_low", seen_low, 1'b1);
    chk("pulse_led", seen_led, 1'b1);
    repeat (110) tick();

    // LED hold and retrigger: second accepted edge 50 clk after the first.
    diob_in = 6'h3E;
    n = 0;
    do begin tick(); n++; end while (diob_led1[0] !== 1'b1 && n < 40);
    chk("led_delay", n, 19);
    on_cnt = 1;
    repeat (31) begin tick(); if (diob_led1[0] === 1'b1) on_cnt++; end
    diob_in = 6'h3F;
    repeat (220) begin tick(); if (diob_led1[0] === 1'b1) on_cnt++; end
    chk("led_retrigger_len", on_cnt, 150);

    // Configuration error flag.
    input_enable  = 8'h01;
    output_enable = 8'h03;
    tick();
    chk("err_set", plugin_error, 1'b1);
    output_enable = 8'h40;
    tick();
    chk("err_clear", plugin_error, 1'b0);
    input_enable  = 8'h3F;
    output_enable = 8'h00;
    repeat (2) tick();

`ifdef IBPL_IN_EDGE_LATCH_EN
    edge_clr = 6'h3F;
    tick();
    edge_clr = 6'h00;
    diob_in  = 6'h37;
    repeat (30) tick();
    edge_clr = 6'h3F;
    tick();
    edge_clr = 6'h00;
    chk("flag_cleared", edge_flag[3], 1'b0);
    diob_in = 6'h3F;
    repeat (30) tick();
    chk("flag_rise_held", edge_flag[3], 1'b1);
    diob_in = 6'h37;
    repeat (18) tick();
    edge_clr = 6'h08;
    tick();
    edge_clr = 6'h00;
    chk("flag_set_wins", edge_flag[3], 1'b1);
    repeat (5) tick();
    edge_clr = 6'h08;
    tick();
    edge_clr = 6'h00;
    chk("flag_clr_alone", edge_flag[3], 1'b0);
    diob_in = 6'h3F;
    repeat (30) tick();
`endif

    // Reset mid-debounce of ch1 with the error flag raised.
    input_enable  = 8'h3D;
    output_enable = 8'h02;
    tick();
    diob_in = 6'h3D;
    repeat (8) tick();
    #2 nReset = 1'b0;
    #1;
    chk("async_rst_in", internal_in, 8'h00);
    chk("async_rst_led1", diob_led1, 8'h00);
    chk("async_rst_err", plugin_error, 1'b0);
    chk("async_rst_dir", diob_dir, 6'h00);
    model_reset();
    diob_in       = 6'h3F;
    input_enable  = 8'h3F;
    output_enable = 8'h00;
    tick();
    tick();
    nReset = 1'b1;
    n = 0;
    do begin tick(); n++; end while (internal_in !== 8'h3F && n < 40);
    chk("rst_reaccept", n, 19);
    chk("rst_reaccept_led", diob_led1, 8'h3F);

    // Randomised phase against the model.
    for (int k = 0; k < 1500; k++) begin
      int ch;
      if ($urandom_range(7) == 0) begin
        ch = int'($urandom_range(5));
        diob_in[ch] = ~diob_in[ch];
      end
      if ($urandom_range(63) == 0) input_enable  = 8'($urandom);
      if ($urandom_range(31) == 0) output_enable = 8'($urandom);
`ifdef IBPL_IN_EDGE_LATCH_EN
      edge_clr = ($urandom_range(15) == 0) ? 6'($urandom) : 6'h00;
`endif
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
